// File: rtl/qoa_slice_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// qoa_slice_sequencer : LMS-state load and slice unpack for mono QOA decode
// Rev 1.0
// ---------------------------------------------------------------------------
module qoa_slice_sequencer #(
  parameter int SLICES_PER_FRAME = 256,
  parameter int SLICE_CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       lms_wr,
  output logic [3:0] lms_idx,
  output logic [7:0] lms_data,
  output logic       dp_valid,
  input  logic       dp_ready,
  output logic [3:0] res_sf,
  output logic [2:0] res_qr,
  output logic       res_last,
  output logic       slice_done,
  output logic       frame_done,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LMS_LOAD   = 2'd1,
    SLICE_LOAD = 2'd2,
    ISSUE      = 2'd3
  } state_t;

  localparam logic [SLICE_CNT_W-1:0] c_LAST_SLICE = SLICE_CNT_W'(SLICES_PER_FRAME - 1);

  state_t                 state_q, state_d;
  logic [3:0]             byte_cnt_q, byte_cnt_d;
  logic [4:0]             res_cnt_q, res_cnt_d;
  logic [SLICE_CNT_W-1:0] slice_cnt_q, slice_cnt_d;
  logic [63:0]            shreg_q, shreg_d;
  logic                   slice_done_q, slice_done_d;
  logic                   frame_done_q, frame_done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      res_cnt_q    <= '0;
      slice_cnt_q  <= '0;
      shreg_q      <= '0;
      slice_done_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      res_cnt_q    <= res_cnt_d;
      slice_cnt_q  <= slice_cnt_d;
      shreg_q      <= shreg_d;
      slice_done_q <= slice_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    res_cnt_d    = res_cnt_q;
    slice_cnt_d  = slice_cnt_q;
    shreg_d      = shreg_q;
    slice_done_d = 1'b0;
    frame_done_d = 1'b0;
    if (abort) begin
      state_d     = IDLE;
      byte_cnt_d  = '0;
      res_cnt_d   = '0;
      slice_cnt_d = '0;
      shreg_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d     = LMS_LOAD;
            byte_cnt_d  = '0;
            slice_cnt_d = '0;
          end
        end
        LMS_LOAD: begin
          if (in_valid) begin
            if (byte_cnt_q == 4'd15) begin
              state_d    = SLICE_LOAD;
              byte_cnt_d = '0;
            end else begin
              byte_cnt_d = byte_cnt_q + 4'd1;
            end
          end
        end
        SLICE_LOAD: begin
          if (in_valid) begin
            shreg_d = {shreg_q[55:0], in_data};
            if (byte_cnt_q == 4'd7) begin
              state_d    = ISSUE;
              byte_cnt_d = '0;
              res_cnt_d  = '0;
            end else begin
              byte_cnt_d = byte_cnt_q + 4'd1;
            end
          end
        end
        ISSUE: begin
          if (dp_ready) begin
            // Scalefactor nibble stays put; residual field shifts up by one code.
            shreg_d = {shreg_q[63:60], shreg_q[56:0], 3'b000};
            if (res_cnt_q == 5'd19) begin
              res_cnt_d    = '0;
              slice_done_d = 1'b1;
              if (slice_cnt_q == c_LAST_SLICE) begin
                frame_done_d = 1'b1;
                slice_cnt_d  = '0;
                state_d      = LMS_LOAD;
              end else begin
                slice_cnt_d = slice_cnt_q + 1'b1;
                state_d     = SLICE_LOAD;
              end
            end else begin
              res_cnt_d = res_cnt_q + 5'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == LMS_LOAD) || (state_q == SLICE_LOAD);
  assign lms_wr     = (state_q == LMS_LOAD) && in_valid;
  assign lms_idx    = byte_cnt_q;
  assign lms_data   = in_data;
  assign dp_valid   = (state_q == ISSUE);
  assign res_sf     = shreg_q[63:60];
  assign res_qr     = shreg_q[59:57];
  assign res_last   = (state_q == ISSUE) && (res_cnt_q == 5'd19);
  assign slice_done = slice_done_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_qoa_slice_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_qoa_slice_sequencer : directed bench, two slices per frame
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_qoa_slice_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       lms_wr;
  logic [3:0] lms_idx;
  logic [7:0] lms_data;
  logic       dp_valid;
  logic       dp_ready = 1'b0;
  logic [3:0] res_sf;
  logic [2:0] res_qr;
  logic       res_last;
  logic       slice_done;
  logic       frame_done;
  logic       busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  qoa_slice_sequencer #(
    .SLICES_PER_FRAME(2),
    .SLICE_CNT_W     (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lms_wr    (lms_wr),
    .lms_idx   (lms_idx),
    .lms_data  (lms_data),
    .dp_valid  (dp_valid),
    .dp_ready  (dp_ready),
    .res_sf    (res_sf),
    .res_qr    (res_qr),
    .res_last  (res_last),
    .slice_done(slice_done),
    .frame_done(frame_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Streams 16 LMS bytes back-to-back and checks each write strobe.
  task automatic run_lms(input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      #1;
      total_cnt++;
      if (lms_wr !== 1'b1 || lms_idx !== 4'(i) || lms_data !== base + 8'(i) || in_ready !== 1'b1)
        $display("FAIL lms_byte%0d: wr=%b idx=%0d data=%h rdy=%b, want wr=1 idx=%0d data=%h rdy=1",
                 i, lms_wr, lms_idx, lms_data, in_ready, i, base + 8'(i));
      else pass_cnt++;
      tick();
    end
    in_valid = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1 || lms_wr !== 1'b0 || busy !== 1'b1 || dp_valid !== 1'b0)
      $display("FAIL after_lms: rdy=%b wr=%b busy=%b dpv=%b, want 1 0 1 0",
               in_ready, lms_wr, busy, dp_valid);
    else pass_cnt++;
  endtask

  // Loads one slice then drains its 20 commands; toggle=1 gives dp_ready 1010...
  task automatic run_slice(input logic [63:0] s, input bit toggle, input bit exp_frame);
    int k;
    int cyc;
    logic [2:0] qr_exp;
    for (int b = 0; b < 8; b++) begin
      in_valid = 1'b1;
      in_data  = s[63-8*b -: 8];
      #1;
      total_cnt++;
      if (in_ready !== 1'b1 || dp_valid !== 1'b0)
        $display("FAIL slice_byte%0d: rdy=%b dpv=%b, want rdy=1 dpv=0", b, in_ready, dp_valid);
      else pass_cnt++;
      tick();
    end
    in_valid = 1'b0;
    k = 0;
    cyc = 0;
    while (k < 20 && cyc < 80) begin
      dp_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      qr_exp = s[59-3*k -: 3];
      total_cnt++;
      if (dp_valid !== 1'b1 || res_sf !== s[63:60] || res_qr !== qr_exp ||
          res_last !== (k == 19) || in_ready !== 1'b0 || slice_done !== 1'b0)
        $display("FAIL cmd%0d: dpv=%b sf=%h qr=%0d last=%b rdy=%b sd=%b, want 1 %h %0d %b 0 0",
                 k, dp_valid, res_sf, res_qr, res_last, in_ready, slice_done,
                 s[63:60], qr_exp, (k == 19));
      else pass_cnt++;
      tick();
      if (dp_ready) k++;
      cyc++;
    end
    dp_ready = 1'b0;
    total_cnt++;
    if (k < 20) $display("FAIL issue_timeout: commands=%0d, want 20", k);
    else pass_cnt++;
    total_cnt++;
    if (slice_done !== 1'b1 || frame_done !== exp_frame || in_ready !== 1'b1 || dp_valid !== 1'b0)
      $display("FAIL slice_end: sd=%b fd=%b rdy=%b dpv=%b, want 1 %b 1 0",
               slice_done, frame_done, in_ready, dp_valid, exp_frame);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (slice_done !== 1'b0 || frame_done !== 1'b0)
      $display("FAIL pulse_width: sd=%b fd=%b, want 0 0", slice_done, frame_done);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    #12;
    total_cnt++;
    if ({in_ready, lms_wr, dp_valid, slice_done, frame_done, busy, res_sf, res_qr, res_last} !== 16'h0)
      $display("FAIL reset_outputs: rdy=%b wr=%b dpv=%b sd=%b fd=%b busy=%b sf=%h qr=%h last=%b, want all 0",
               in_ready, lms_wr, dp_valid, slice_done, frame_done, busy, res_sf, res_qr, res_last);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    tick();
    total_cnt++;
    if (busy !== 1'b0 || in_ready !== 1'b0) $display("FAIL idle: busy=%b rdy=%b, want 0 0", busy, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_lms_load();
    pulse_start();
    run_lms(8'h00);
  endtask

  task automatic test_slice_basic();
    run_slice(64'hA000_0000_0000_0007, 1'b0, 1'b0);
  endtask

  task automatic test_slice_stall();
    run_slice(64'h3FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back_frames();
    run_lms(8'h80);
    run_slice(64'h5123_4567_89AB_CDEF, 1'b0, 1'b0);
    run_slice(64'hF0F0_F0F0_0F0F_0F0F, 1'b0, 1'b1);
  endtask

  task automatic test_abort();
    run_lms(8'h20);
    for (int b = 0; b < 8; b++) begin
      in_valid = 1'b1;
      in_data  = 8'h77;
      tick();
    end
    in_valid = 1'b0;
    dp_ready = 1'b1;
    repeat (5) tick();
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    dp_ready = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || dp_valid !== 1'b0 || slice_done !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL abort_idle: busy=%b dpv=%b sd=%b rdy=%b, want 0 0 0 0",
               busy, dp_valid, slice_done, in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (busy !== 1'b0 || slice_done !== 1'b0)
      $display("FAIL abort_hold: busy=%b sd=%b, want 0 0", busy, slice_done);
    else pass_cnt++;
    pulse_start();
    total_cnt++;
    if (busy !== 1'b1 || lms_idx !== 4'd0 || in_ready !== 1'b1)
      $display("FAIL restart: busy=%b idx=%0d rdy=%b, want 1 0 1", busy, lms_idx, in_ready);
    else pass_cnt++;
    run_lms(8'h30);
  endtask

  task automatic test_async_reset();
    for (int b = 0; b < 3; b++) begin
      in_valid = 1'b1;
      in_data  = 8'hC3;
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({in_ready, lms_wr, dp_valid, slice_done, frame_done, busy, res_sf, res_qr, res_last, lms_idx} !== 20'h0)
      $display("FAIL async_reset: rdy=%b wr=%b dpv=%b sd=%b fd=%b busy=%b sf=%h qr=%h last=%b idx=%0d, want all 0",
               in_ready, lms_wr, dp_valid, slice_done, frame_done, busy, res_sf, res_qr, res_last, lms_idx);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    tick();
    pulse_start();
    run_lms(8'h40);
    run_slice(64'h9876_5432_10FE_DCBA, 1'b0, 1'b0);
    run_slice(64'h1111_2222_3333_4444, 1'b1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_lms_load();
    test_slice_basic();
    test_slice_stall();
    test_back_to_back_frames();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
